// File: rtl/comparator_seq.sv
// Multi-cycle magnitude comparator: compares a and b MSB-first, CHUNK bits per clock.
// Optional build macro COMPARATOR_SEQ_EARLY_EXIT_EN finishes at the first differing chunk.
module comparator_seq #(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         is_signed,
    input  logic [2:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out,
    output logic         lt,
    output logic         eq,
    output logic         gt
);

    localparam int CHUNKS = N / CHUNK;
    localparam int IDXW   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    generate
        if (N % CHUNK != 0) begin : g_bad_chunk
            $error("comparator_seq: N must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t            state;
    logic [N-1:0]      a_r;
    logic [N-1:0]      b_r;
    logic [2:0]        op_r;
    logic [IDXW-1:0]   idx;
    logic              lt_r;
    logic              gt_r;

    logic [N-1:0]      sign_flip;
    logic [CHUNK-1:0]  a_c;
    logic [CHUNK-1:0]  b_c;
    logic              nlt;
    logic              ngt;
    logic              neq;
    logic              last;
    logic              result;

    assign in_ready = (state == IDLE);

    // Operand copies shift left each cycle so the chunk under test is always the top slice.
    always_comb begin
        sign_flip        = '0;
        sign_flip[N-1]   = is_signed;
        a_c              = a_r[N-1 -: CHUNK];
        b_c              = b_r[N-1 -: CHUNK];
        nlt              = lt_r;
        ngt              = gt_r;
        if (!lt_r && !gt_r) begin
            nlt = (a_c < b_c);
            ngt = (a_c > b_c);
        end
        neq  = ~nlt & ~ngt;
        last = (idx == '0) || (EARLY_EXIT && (nlt || ngt));
        case (op_r)
            3'd0:    result = neq;
            3'd1:    result = ~neq;
            3'd2:    result = nlt;
            3'd3:    result = nlt | neq;
            3'd4:    result = ngt;
            3'd5:    result = ngt | neq;
            default: result = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            op_r      <= '0;
            idx       <= IDXW'(CHUNKS - 1);
            lt_r      <= 1'b0;
            gt_r      <= 1'b0;
            out_valid <= 1'b0;
            out       <= 1'b0;
            lt        <= 1'b0;
            eq        <= 1'b0;
            gt        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a ^ sign_flip;
                        b_r   <= b ^ sign_flip;
                        op_r  <= op;
                        idx   <= IDXW'(CHUNKS - 1);
                        lt_r  <= 1'b0;
                        gt_r  <= 1'b0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    a_r  <= a_r << CHUNK;
                    b_r  <= b_r << CHUNK;
                    lt_r <= nlt;
                    gt_r <= ngt;
                    idx  <= idx - 1'b1;
                    if (last) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out       <= result;
                        lt        <= nlt;
                        eq        <= neq;
                        gt        <= ngt;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_comparator_seq.sv
// Randomised self-checking bench for comparator_seq (N=32, CHUNK=8).
// Reference results come from plain signed/unsigned arithmetic on the full operands.
module tb_comparator_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        is_signed;
    logic [2:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic        out;
    logic        lt;
    logic        eq;
    logic        gt;

    int unsigned errors = 0;
    int unsigned checks = 0;

    comparator_seq #(.N(32), .CHUNK(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .lt        (lt),
        .eq        (eq),
        .gt        (gt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_latency(input logic [31:0] x, input logic [31:0] y);
`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
        for (int k = 0; k < 4; k++)
            if (x[31 - 8*k -: 8] != y[31 - 8*k -: 8]) return k + 1;
`endif
        return 4;
    endfunction

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic s,
                          input logic [2:0] o, input int hold);
        logic el, ee, eg, eo;
        int   cycles;
        if (s) begin
            el = $signed(ta) < $signed(tb_v);
            eg = $signed(ta) > $signed(tb_v);
        end else begin
            el = ta < tb_v;
            eg = ta > tb_v;
        end
        ee = (ta == tb_v);
        case (o)
            3'd0: eo = ee;
            3'd1: eo = !ee;
            3'd2: eo = el;
            3'd3: eo = el || ee;
            3'd4: eo = eg;
            3'd5: eo = eg || ee;
            default: eo = 1'b0;
        endcase

        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        a = ta; b = tb_v; is_signed = s; op = o;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; is_signed = ~s; op = 3'($urandom);
        check("in_ready_busy", 32'(in_ready), 32'd0);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("latency", 32'(cycles), 32'(exp_latency(ta, tb_v)));
        check("out", 32'(out), 32'(eo));
        check("flags", {29'd0, lt, eq, gt}, {29'd0, el, ee, eg});

        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = $urandom; b = $urandom;
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_out", {28'd0, out, lt, eq, gt}, {28'd0, eo, el, ee, eg});
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_valid", 32'(out_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; is_signed = 1'b0; op = '0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_outputs", {28'd0, out, lt, eq, gt}, 32'd0);
        @(negedge clk); rst = 1'b0;

        run_op(32'hFFFF_FFFF, 32'd1, 1'b1, 3'd2, 0);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 3'd2, 0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 3'd3, 0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 3'd3, 0);
        run_op(32'h0100_0000, 32'h00FF_FFFF, 1'b0, 3'd4, 0);
        run_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'd5, 0);
        run_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'd1, 0);
        run_op(32'h1234_5678, 32'h1234_5679, 1'b0, 3'd0, 5);

        // Reset during the second BUSY cycle must drop the transaction entirely.
        @(negedge clk);
        a = 32'h0000_0005; b = 32'h0000_0003; is_signed = 1'b0; op = 3'd4;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("midrst_no_stale", 32'(out_valid), 32'd0);
        end
        run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 3'd6, 1);

        for (int t = 0; t < 40; t++) begin
            ra = $urandom;
            case ($urandom_range(3))
                0: rb = ra;
                1: rb = ra ^ (32'd1 << $urandom_range(31));
                default: rb = $urandom;
            endcase
            run_op(ra, rb, 1'($urandom), 3'($urandom), int'($urandom_range(2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
